// File: rtl/control_sequencer.sv
// Hardwired control unit for the ALU-system datapath: two-byte fetch, decode, 1-2 cycle execute.
// Optional: define CU_ILLEGAL_HALT_EN to halt on an illegal opcode instead of skipping it.
module control_sequencer #(
    parameter logic [4:0] ALU_PASSB = 5'b00001,
    parameter logic [4:0] ALU_ADD   = 5'b00100,
    parameter logic [4:0] ALU_SUB   = 5'b00110,
    parameter logic [4:0] ALU_AND   = 5'b00111,
    parameter logic [4:0] ALU_ORR   = 5'b01000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic        ALU_WF,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [1:0]  SC,
    output logic        Halted,
    output logic        Illegal
);

    typedef enum logic [2:0] {FETCH_L, FETCH_H, EXEC, EXEC2, HALT} state_t;

    localparam logic [5:0] OP_BRA = 6'h00, OP_BNE = 6'h01, OP_BEQ = 6'h02, OP_MOVL = 6'h03;
    localparam logic [5:0] OP_INC = 6'h04, OP_DEC = 6'h05, OP_ADD = 6'h06, OP_SUB = 6'h07;
    localparam logic [5:0] OP_AND = 6'h08, OP_ORR = 6'h09, OP_LD = 6'h0A, OP_ST = 6'h0B;
    localparam logic [5:0] OP_HLT = 6'h3F;

    localparam logic [2:0] FUN_DEC = 3'b000, FUN_INC = 3'b001, FUN_LOAD = 3'b010;

    state_t      state, state_nxt;
    logic [1:0]  sc_nxt;
    logic        illegal_set;

    logic [5:0]  opcode;
    logic [1:0]  rx;
    logic [3:0]  rx_hot, dst_hot;
    logic        flag_z;
    logic        unused_flags;

    assign opcode       = IROut[15:10];
    assign rx           = IROut[9:8];
    assign rx_hot       = 4'b0001 << rx;
    assign dst_hot      = 4'b0001 << IROut[7:6];
    assign flag_z       = ALUOutFlag[3];
    assign unused_flags = ^ALUOutFlag[2:0];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= FETCH_L;
            SC      <= '0;
            Halted  <= 1'b0;
            Illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            SC      <= sc_nxt;
            Halted  <= (state_nxt == HALT);
            Illegal <= illegal_set;
        end
    end

    always_comb begin
        case (state_nxt)
            FETCH_L: sc_nxt = 2'd0;
            FETCH_H: sc_nxt = 2'd1;
            EXEC2:   sc_nxt = 2'd3;
            default: sc_nxt = 2'd2;
        endcase
    end

    // Outputs are forced idle while reset is asserted, so a reset mid-store releases the bus at once.
    always_comb begin
        RF_OutASel  = '0;
        RF_OutBSel  = '0;
        RF_FunSel   = '0;
        RF_RegSel   = '0;
        RF_ScrSel   = '0;
        ALU_FunSel  = '0;
        ARF_OutCSel = '0;
        ARF_OutDSel = '0;
        ARF_FunSel  = '0;
        ARF_RegSel  = '0;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        ALU_WF      = 1'b0;
        MuxASel     = '0;
        MuxBSel     = '0;
        MuxCSel     = 1'b0;
        state_nxt   = state;
        illegal_set = 1'b0;
        if (Reset) begin
            case (state)
                FETCH_L, FETCH_H: begin
                    Mem_CS     = 1'b0;
                    IR_LH      = (state == FETCH_H);
                    IR_Write   = 1'b1;
                    ARF_RegSel = 3'b100;
                    ARF_FunSel = FUN_INC;
                    state_nxt  = (state == FETCH_L) ? FETCH_H : EXEC;
                end
                EXEC: begin
                    state_nxt = FETCH_L;
                    case (opcode)
                        OP_BRA, OP_BNE, OP_BEQ: begin
                            if (opcode == OP_BRA || (opcode == OP_BNE && !flag_z) ||
                                (opcode == OP_BEQ && flag_z)) begin
                                MuxBSel    = 2'b10;
                                ARF_RegSel = 3'b100;
                                ARF_FunSel = FUN_LOAD;
                            end
                        end
                        OP_MOVL: begin
                            MuxASel   = 2'b10;
                            RF_FunSel = FUN_LOAD;
                            RF_RegSel = rx_hot;
                        end
                        OP_INC, OP_DEC: begin
                            RF_FunSel = (opcode == OP_INC) ? FUN_INC : FUN_DEC;
                            RF_RegSel = rx_hot;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                            RF_OutASel = IROut[5:3];
                            RF_OutBSel = IROut[2:0];
                            case (opcode)
                                OP_ADD:  ALU_FunSel = ALU_ADD;
                                OP_SUB:  ALU_FunSel = ALU_SUB;
                                OP_AND:  ALU_FunSel = ALU_AND;
                                default: ALU_FunSel = ALU_ORR;
                            endcase
                            ALU_WF    = 1'b1;
                            RF_FunSel = FUN_LOAD;
                            RF_RegSel = dst_hot;
                        end
                        OP_LD: begin
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            state_nxt   = EXEC2;
                        end
                        OP_ST: begin
                            RF_OutBSel  = {1'b0, rx};
                            ALU_FunSel  = ALU_PASSB;
                            ARF_OutDSel = 2'b10;
                            state_nxt   = EXEC2;
                        end
                        OP_HLT: state_nxt = HALT;
                        default: begin
                            illegal_set = 1'b1;
`ifdef CU_ILLEGAL_HALT_EN
                            state_nxt   = HALT;
`else
                            state_nxt   = FETCH_L;
`endif
                        end
                    endcase
                end
                EXEC2: begin
                    ARF_OutDSel = 2'b10;
                    Mem_CS      = 1'b0;
                    if (opcode == OP_ST) begin
                        RF_OutBSel = {1'b0, rx};
                        ALU_FunSel = ALU_PASSB;
                        Mem_WR     = 1'b1;
                    end else begin
                        MuxASel   = 2'b11;
                        RF_FunSel = FUN_LOAD;
                        RF_RegSel = rx_hot;
                    end
                    state_nxt = FETCH_L;
                end
                HALT:    state_nxt = HALT;
                default: state_nxt = FETCH_L;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed table, corner sequences and a
// randomized instruction stream checked against a per-instruction cycle model.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_CS, Mem_WR, ALU_WF;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [1:0]  SC;
    logic        Halted, Illegal;

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_CS(Mem_CS),
        .Mem_WR(Mem_WR), .ALU_WF(ALU_WF), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .SC(SC), .Halted(Halted), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0] rf_a;
        logic [2:0] rf_b;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu;
        logic [1:0] arf_c;
        logic [1:0] arf_d;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_wr;
        logic       cs;
        logic       wr;
        logic       wf;
        logic [1:0] mua;
        logic [1:0] mub;
        logic       muc;
        logic [1:0] sc;
        logic       halted;
        logic       illegal;
    } ctl_t;

    ctl_t act;
    assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel,
                  ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write,
                  Mem_CS, Mem_WR, ALU_WF, MuxASel, MuxBSel, MuxCSel, SC, Halted, Illegal};

`ifdef CU_ILLEGAL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit pend_ill = 1'b0;

    task automatic check(input string tag, input ctl_t e);
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (SC got %0d req %0d)", tag, act, e, act.sc, e.sc);
        end
    endtask

    function automatic ctl_t idle_c(input logic [1:0] sc);
        ctl_t e = '0;
        e.cs = 1'b1;
        e.sc = sc;
        return e;
    endfunction

    function automatic bit is_illegal(input logic [15:0] ir);
        int op = int'(ir[15:10]);
        return !(op <= 11 || op == 63);
    endfunction

    // Expected control word for cycle `cyc` (0..3) of instruction `ir`.
    function automatic ctl_t model(input logic [15:0] ir, input int cyc, input logic z);
        ctl_t e = idle_c(2'(cyc));
        int op = int'(ir[15:10]);
        int rx = int'(ir[9:8]);
        logic [3:0] rx_hot = 4'(1 << rx);
        logic [3:0] dst_hot = 4'(1 << int'(ir[7:6]));
        if (cyc < 2) begin
            e.cs = 0; e.ir_wr = 1; e.ir_lh = (cyc == 1); e.arf_reg = 3'b100; e.arf_fun = 3'b001;
        end else if (cyc == 2) begin
            if (op == 0 || (op == 1 && !z) || (op == 2 && z)) begin
                e.mub = 2; e.arf_reg = 3'b100; e.arf_fun = 3'b010;
            end else if (op == 3) begin
                e.mua = 2; e.rf_fun = 3'b010; e.rf_reg = rx_hot;
            end else if (op == 4 || op == 5) begin
                e.rf_fun = (op == 4) ? 3'b001 : 3'b000; e.rf_reg = rx_hot;
            end else if (op >= 6 && op <= 9) begin
                e.rf_a = ir[5:3]; e.rf_b = ir[2:0]; e.wf = 1;
                e.alu = (op == 6) ? 5'b00100 : (op == 7) ? 5'b00110 : (op == 8) ? 5'b00111 : 5'b01000;
                e.rf_fun = 3'b010; e.rf_reg = dst_hot;
            end else if (op == 10) begin
                e.arf_d = 2; e.cs = 0;
            end else if (op == 11) begin
                e.rf_b = 3'(rx); e.alu = 5'b00001; e.arf_d = 2;
            end
        end else begin
            e.arf_d = 2; e.cs = 0;
            if (op == 11) begin
                e.rf_b = 3'(rx); e.alu = 5'b00001; e.wr = 1;
            end else begin
                e.mua = 3; e.rf_fun = 3'b010; e.rf_reg = rx_hot;
            end
        end
        return e;
    endfunction

    task automatic do_reset();
        Reset = 1'b0;
        #1;
        check("reset_idle", idle_c(2'd0));
        @(posedge Clock); #1;
        Reset = 1'b1;
        pend_ill = 1'b0;
    endtask

    // Runs one instruction starting at posedge+1 in FETCH_L; optional table override for EXEC.
    task automatic run_instr(input logic [15:0] ir, input logic z, input string tag,
                             input bit use_tbl, input ctl_t tbl_exp);
        int op = int'(ir[15:10]);
        int ncyc = (op == 10 || op == 11) ? 4 : 3;
        bit ill = is_illegal(ir);
        bit halts = (op == 63) || (HALT_EN && ill);
        ctl_t e;
        for (int c = 0; c < ncyc; c++) begin
            IROut = ir;
            ALUOutFlag = {z, 3'($urandom_range(0, 7))};
            #1;
            e = model(ir, c, z);
            if (c == 0) e.illegal = pend_ill;
            if (c == 2 && use_tbl) e = tbl_exp;
            check($sformatf("%s_c%0d", tag, c), e);
            @(posedge Clock); #1;
        end
        if (halts) begin
            for (int k = 0; k < 3; k++) begin
                IROut = 16'($urandom);
                ALUOutFlag = 4'($urandom);
                #1;
                e = idle_c(2'd2);
                e.halted = 1'b1;
                e.illegal = (k == 0) ? ill : 1'b0;
                check($sformatf("%s_halt%0d", tag, k), e);
                @(posedge Clock); #1;
            end
            do_reset();
        end else begin
            pend_ill = ill;
        end
    endtask

    typedef struct {
        logic [15:0] ir;
        logic        z;
        string       name;
        ctl_t        exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        ctl_t e;
        Reset = 1'b0;
        IROut = '0;
        ALUOutFlag = '0;

        tbl[0] = '{16'h0D5A, 1'b0, "movl", idle_c(2)};
        tbl[0].exp.mua = 2; tbl[0].exp.rf_fun = 3'b010; tbl[0].exp.rf_reg = 4'b0010;
        tbl[1] = '{16'h1853, 1'b0, "add", idle_c(2)};
        tbl[1].exp.rf_a = 3'b010; tbl[1].exp.rf_b = 3'b011; tbl[1].exp.alu = 5'b00100;
        tbl[1].exp.wf = 1; tbl[1].exp.rf_fun = 3'b010; tbl[1].exp.rf_reg = 4'b0010;
        tbl[2] = '{16'h0440, 1'b1, "bne_z1", idle_c(2)};
        tbl[3] = '{16'h0440, 1'b0, "bne_z0", idle_c(2)};
        tbl[3].exp.arf_reg = 3'b100; tbl[3].exp.arf_fun = 3'b010; tbl[3].exp.mub = 2;
        tbl[4] = '{16'h2D00, 1'b0, "st", idle_c(2)};
        tbl[4].exp.rf_b = 3'b001; tbl[4].exp.alu = 5'b00001; tbl[4].exp.arf_d = 2;
        tbl[5] = '{16'h0880, 1'b1, "beq_z1", idle_c(2)};
        tbl[5].exp.arf_reg = 3'b100; tbl[5].exp.arf_fun = 3'b010; tbl[5].exp.mub = 2;
        tbl[6] = '{16'h11C0, 1'b0, "inc", idle_c(2)};
        tbl[6].exp.rf_fun = 3'b001; tbl[6].exp.rf_reg = 4'b0010;
        tbl[7] = '{16'h2B00, 1'b0, "ld", idle_c(2)};
        tbl[7].exp.arf_d = 2; tbl[7].exp.cs = 0;

        #2;
        check("reset_state", idle_c(2'd0));
        @(posedge Clock); #1;
        Reset = 1'b1;

        foreach (tbl[i]) run_instr(tbl[i].ir, tbl[i].z, tbl[i].name, 1'b1, tbl[i].exp);

        // Reset asserted in the write cycle of a store.
        for (int c = 0; c < 4; c++) begin
            IROut = 16'h2D00;
            ALUOutFlag = '0;
            #1;
            e = model(16'h2D00, c, 1'b0);
            if (c == 0) e.illegal = pend_ill;
            check($sformatf("st_rst_c%0d", c), e);
            if (c < 3) begin
                @(posedge Clock); #1;
            end
        end
        do_reset();
        run_instr(16'h0D5A, 1'b0, "after_rst", 1'b0, '0);

        run_instr(16'hC000, 1'b0, "illegal", 1'b0, '0);
        run_instr(16'h0D5A, 1'b0, "post_ill", 1'b0, '0);
        run_instr(16'hFC00, 1'b0, "hlt", 1'b0, '0);

        for (int n = 0; n < 150; n++) begin
            int r = $urandom_range(0, 19);
            logic [5:0] op;
            if (r < 12)      op = 6'(r);
            else if (r < 17) op = 6'($urandom_range(12, 62));
            else if (r < 19) op = 6'($urandom_range(0, 11));
            else             op = 6'h3F;
            run_instr({op, 10'($urandom)}, 1'($urandom), $sformatf("rnd%0d", n), 1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
